// File: rtl/memory_master_pkg.sv
// Shared types and default geometry for the memory_master burst engine.
// Imported by the top and by the burst counter.
package memory_master_pkg;

    localparam int DEF_WORD_SIZE = 16;
    localparam int DEF_ADDR_SIZE = 16;
    localparam int DEF_LEN_SIZE  = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_RD_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/memory_master_burst_counter.sv
// Burst address/length tracker: loads the start address and word count,
// steps one word at a time with natural address wrap, flags the final word.
module burst_counter
    import memory_master_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int LEN_SIZE  = DEF_LEN_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [ADDR_SIZE-1:0] i_addr,
    input  logic [LEN_SIZE-1:0]  i_len,
    output logic [ADDR_SIZE-1:0] o_addr,
    output logic [LEN_SIZE-1:0]  o_remaining,
    output logic                 o_last
);

    logic [ADDR_SIZE-1:0] r_addr;
    logic [LEN_SIZE-1:0]  r_remaining;

    // Address and remaining-count registers; load wins over step.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_addr      <= i_addr;
            r_remaining <= i_len;
        end else if (i_step) begin
            r_addr      <= r_addr + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
            r_remaining <= r_remaining - {{(LEN_SIZE-1){1'b0}}, 1'b1};
        end else begin
            r_addr      <= r_addr;
            r_remaining <= r_remaining;
        end
    end

    assign o_addr      = r_addr;
    assign o_remaining = r_remaining;
    assign o_last      = (r_remaining == '0);

endmodule

// File: rtl/memory_master.sv
// Burst master for a single-port synchronous memory: write bursts at one
// word per cycle, read bursts at three cycles per word with valid/ready out.
module memory_master
    import memory_master_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int LEN_SIZE  = DEF_LEN_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [LEN_SIZE-1:0]  req_len,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [WORD_SIZE-1:0] wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 rd_last,
    output logic                 done,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_data_in,
    output logic                 mem_we,
    output logic                 mem_oe,
    input  logic [WORD_SIZE-1:0] mem_data_out
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [WORD_SIZE-1:0] r_rd_data;
    logic                 r_done;

    logic [ADDR_SIZE-1:0] w_cur_addr;
    logic [LEN_SIZE-1:0]  w_remaining;
    logic                 w_last;
    logic                 w_load;
    logic                 w_step;
    logic                 w_mem_we;
    logic                 w_mem_oe;
    logic [WORD_SIZE-1:0] w_mem_data_in;

    burst_counter #(
        .ADDR_SIZE (ADDR_SIZE),
        .LEN_SIZE  (LEN_SIZE)
    ) u_burst_counter (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_addr      (req_addr),
        .i_len       (req_len),
        .o_addr      (w_cur_addr),
        .o_remaining (w_remaining),
        .o_last      (w_last)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read-data capture (only in the cycle the memory drives its output) and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
            r_done    <= 1'b0;
        end else begin
            if (r_state == ST_RD_WAIT) begin
                r_rd_data <= mem_data_out;
            end else begin
                r_rd_data <= r_rd_data;
            end
            r_done <= w_step & w_last;
        end
    end

    // Next-state, handshake and memory-strobe decode.
    always_comb begin
        w_state_nxt   = r_state;
        req_ready     = 1'b0;
        wr_ready      = 1'b0;
        rd_valid      = 1'b0;
        rd_last       = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_oe      = 1'b0;
        w_mem_data_in = '0;
        w_load        = 1'b0;
        w_step        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = req_write ? ST_WRITE : ST_RD_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                wr_ready      = 1'b1;
                w_mem_we      = wr_valid;
                w_mem_data_in = wr_data;
                if (wr_valid) begin
                    w_step      = 1'b1;
                    w_state_nxt = w_last ? ST_IDLE : ST_WRITE;
                end else begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_RD_ISSUE: begin
                w_mem_oe    = 1'b1;
                w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                w_state_nxt = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                rd_valid = 1'b1;
                rd_last  = w_last;
                if (rd_ready) begin
                    w_step      = 1'b1;
                    w_state_nxt = w_last ? ST_IDLE : ST_RD_ISSUE;
                end else begin
                    w_state_nxt = ST_RD_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Strobes are forced low while reset is held, whatever state is current.
    assign mem_we      = w_mem_we & ~rst;
    assign mem_oe      = w_mem_oe & ~rst;
    assign mem_addr    = w_cur_addr;
    assign mem_data_in = w_mem_data_in;
    assign rd_data     = r_rd_data;
    assign done        = r_done;

endmodule

// File: tb/tb_memory_master.sv
// Directed bench for memory_master with a behavioural synchronous memory:
// a table of burst vectors plus hand sequences for read stall and mid-burst reset.
module tb_memory_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [3:0]  req_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_last;
    logic        done;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_we;
    logic        mem_oe;
    logic [15:0] mem_data_out;

    always #5 clk = ~clk;

    memory_master #(
        .WORD_SIZE (16),
        .ADDR_SIZE (16),
        .LEN_SIZE  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_we       (mem_we),
        .mem_oe       (mem_oe),
        .mem_data_out (mem_data_out)
    );

    // Memory: synchronous write, registered read driven for one cycle after oe.
    // Outside that cycle a junk pattern stands in for high-Z.
    logic [15:0] mem [0:65535];
    logic [15:0] mem_q;
    logic        mem_q_vld = 1'b0;
    int          we_cnt = 0;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data_in;
            we_cnt        <= we_cnt + 1;
        end
        mem_q_vld <= mem_oe;
        if (mem_oe) mem_q <= mem[mem_addr];
    end

    assign mem_data_out = mem_q_vld ? mem_q : 16'hDEAD;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Strobe exclusion monitor.
    always @(negedge clk) begin
        #2;
        n_vec++;
        if (mem_we && mem_oe) begin
            n_bad++;
            $display("FAIL we_oe_exclusive: both high at %0t", $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic             wr;
        logic [15:0]      addr;
        logic [3:0]       len;
        logic [3:0][15:0] words;
        logic [15:0]      pat;
        int               exp_cyc;
    } vec_t;

    vec_t tbl [6];

    task automatic do_write(input vec_t v);
        int          cyc;
        int          idx;
        int          we0;
        logic [15:0] ea;
        we0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = v.addr; req_len = v.len;
        #1;
        chk("wr_req_ready_idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0;
        cyc = 0; idx = 0;
        while (!done && cyc < 100) begin
            wr_valid = v.pat[cyc[3:0]];
            wr_data  = v.words[idx[1:0]];
            #1;
            ea = v.addr + 16'(idx);
            chk("wr_req_ready_busy", 32'(req_ready), 32'd0);
            chk("wr_ready", 32'(wr_ready), 32'd1);
            chk("wr_mem_we", 32'(mem_we), 32'(wr_valid));
            chk("wr_mem_oe", 32'(mem_oe), 32'd0);
            chk("wr_mem_addr", 32'(mem_addr), 32'(ea));
            if (wr_valid) idx++;
            @(negedge clk);
            cyc++;
        end
        wr_valid = 1'b0; wr_data = 16'h0000;
        chk("wr_done_cycles", 32'(cyc), 32'(v.exp_cyc));
        chk("wr_done_high", 32'(done), 32'd1);
        chk("wr_word_count", 32'(we_cnt - we0), 32'(int'(v.len) + 1));
        for (int i = 0; i <= int'(v.len); i++) begin
            chk("wr_mem_content", 32'(mem[v.addr + 16'(i)]), 32'(v.words[i]));
        end
        @(negedge clk);
        chk("wr_done_pulse", 32'(done), 32'd0);
    endtask

    task automatic do_read(input vec_t v);
        int          cyc;
        int          idx;
        int          first;
        int          n_oe;
        logic [15:0] ea;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = v.addr; req_len = v.len;
        #1;
        chk("rd_req_ready_idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0; idx = 0; first = -1; n_oe = 0;
        while (!done && cyc < 200) begin
            rd_ready = v.pat[cyc[3:0]];
            #1;
            chk("rd_req_ready_busy", 32'(req_ready), 32'd0);
            if (mem_oe) begin
                n_oe++;
                ea = v.addr + 16'(idx);
                chk("rd_mem_addr", 32'(mem_addr), 32'(ea));
            end
            if (rd_valid) begin
                if (first < 0) first = cyc;
                chk("rd_data", 32'(rd_data), 32'(v.words[idx[1:0]]));
                chk("rd_last", 32'(rd_last), 32'(idx == int'(v.len)));
                if (rd_ready) idx++;
            end
            @(negedge clk);
            cyc++;
        end
        rd_ready = 1'b0;
        chk("rd_done_cycles", 32'(cyc), 32'(v.exp_cyc));
        chk("rd_first_valid", 32'(first), 32'd2);
        chk("rd_oe_count", 32'(n_oe), 32'(int'(v.len) + 1));
        chk("rd_word_count", 32'(idx), 32'(int'(v.len) + 1));
        chk("rd_done_high", 32'(done), 32'd1);
        @(negedge clk);
        chk("rd_done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        int          cyc;
        int          we0;
        logic [15:0] pre2;
        logic [15:0] pre3;

        tbl[0] = '{1'b1, 16'h0010, 4'd3, {16'hA003, 16'hA002, 16'hA001, 16'hA000}, 16'hFFFF, 4};
        tbl[1] = '{1'b0, 16'h0010, 4'd3, {16'hA003, 16'hA002, 16'hA001, 16'hA000}, 16'hFFFF, 12};
        tbl[2] = '{1'b1, 16'hFFFF, 4'd1, {16'h0000, 16'h0000, 16'h2222, 16'h1111}, 16'hFFFF, 2};
        tbl[3] = '{1'b0, 16'hFFFF, 4'd1, {16'h0000, 16'h0000, 16'h2222, 16'h1111}, 16'hFFFF, 6};
        tbl[4] = '{1'b1, 16'h0100, 4'd2, {16'h0000, 16'hB002, 16'hB001, 16'hB000}, 16'h0025, 6};
        tbl[5] = '{1'b0, 16'h0100, 4'd2, {16'h0000, 16'hB002, 16'hB001, 16'hB000}, 16'hFFFF, 9};

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0000; req_len = 4'd0;
        wr_valid = 1'b0; wr_data = 16'h0000; rd_ready = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_oe", 32'(mem_oe), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data_in", 32'(mem_data_in), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].wr) do_write(tbl[i]);
            else           do_read(tbl[i]);
        end

        // Read held off by the consumer for five cycles.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0012; req_len = 4'd0; rd_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (!rd_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("stall_latency", 32'(cyc), 32'd2);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_rd_valid", 32'(rd_valid), 32'd1);
            chk("stall_rd_data", 32'(rd_data), 32'hA002);
            chk("stall_rd_last", 32'(rd_last), 32'd1);
            chk("stall_no_oe", 32'(mem_oe), 32'd0);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rd_ready = 1'b1;
        #1;
        chk("stall_release_valid", 32'(rd_valid), 32'd1);
        @(negedge clk);
        rd_ready = 1'b0;
        chk("stall_done", 32'(done), 32'd1);
        chk("stall_valid_drop", 32'(rd_valid), 32'd0);
        @(negedge clk);
        chk("stall_done_pulse", 32'(done), 32'd0);

        // Reset after two of four write words.
        pre2 = mem[16'h0202];
        pre3 = mem[16'h0203];
        we0  = we_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0200; req_len = 4'd3;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0;
        wr_valid = 1'b1; wr_data = 16'hC000;
        @(negedge clk);
        wr_data = 16'hC001;
        @(negedge clk);
        rst = 1'b1; wr_data = 16'hC002;
        #1;
        chk("mid_rst_we_gated", 32'(mem_we), 32'd0);
        chk("mid_rst_oe_gated", 32'(mem_oe), 32'd0);
        @(negedge clk);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0; wr_data = 16'hC003;
        #1;
        chk("post_rst_no_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        chk("post_rst_no_we2", 32'(mem_we), 32'd0);
        wr_valid = 1'b0; wr_data = 16'h0000;
        @(negedge clk);
        chk("mid_rst_word_count", 32'(we_cnt - we0), 32'd2);
        chk("mid_rst_mem0", 32'(mem[16'h0200]), 32'hC000);
        chk("mid_rst_mem1", 32'(mem[16'h0201]), 32'hC001);
        chk("mid_rst_mem2_untouched", 32'(mem[16'h0202]), 32'(pre2));
        chk("mid_rst_mem3_untouched", 32'(mem[16'h0203]), 32'(pre3));
        chk("mid_rst_idle_done", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
